// File: rtl/md_sched.sv
// Multiply/divide scheduler: tracks HI/LO unit occupancy and merges md/data stalls into one Stall.
// Optional stall statistics counter enabled by defining MD_STALL_STATS_EN.
`timescale 1ns/1ps
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic        E_is_div,
    input  logic        D_md_use,
    input  logic        hz_stall,
    output logic        busy,
    output logic        md_done,
    output logic        Stall,
    output logic        E_flush,
    output logic [3:0]  cnt,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt_next;
    logic       md_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A start arriving while the unit is occupied is dropped; the stall rule keeps it from happening.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (E_start) begin
                    if (E_is_div) begin
                        state_next = DIV;
                        cnt_next   = 4'(DIV_CYCLES);
                    end else begin
                        state_next = MULT;
                        cnt_next   = 4'(MULT_CYCLES);
                    end
                end
            end
            MULT, DIV: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    assign busy     = (cnt != 4'd0);
    assign md_done  = (cnt == 4'd1);
    assign md_stall = D_md_use & (busy | E_start);
    assign Stall    = md_stall | hz_stall;
    assign E_flush  = Stall;

`ifdef MD_STALL_STATS_EN
    logic [31:0] stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 32'd0;
        end else if (Stall) begin
            stall_count <= stall_count + 32'd1;
        end
    end

    assign stall_cycles = stall_count;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: a default instance and an N=1/N=15 instance against a
// per-instance remaining-cycles model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        E_start = 1'b0;
    logic        E_is_div = 1'b0;
    logic        D_md_use = 1'b0;
    logic        hz_stall = 1'b0;

    logic        busy_w [2];
    logic        md_done_w [2];
    logic        stall_w [2];
    logic        flush_w [2];
    logic [3:0]  cnt_w [2];
    logic [31:0] stats_w [2];

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    int          mult_n [2] = '{5, 1};
    int          div_n  [2] = '{10, 15};
    int          m_rem  [2] = '{0, 0};
    logic [31:0] m_stats [2] = '{32'd0, 32'd0};

    md_sched dut0 (
        .clk(clk), .reset(reset), .E_start(E_start), .E_is_div(E_is_div),
        .D_md_use(D_md_use), .hz_stall(hz_stall), .busy(busy_w[0]), .md_done(md_done_w[0]),
        .Stall(stall_w[0]), .E_flush(flush_w[0]), .cnt(cnt_w[0]), .stall_cycles(stats_w[0])
    );

    md_sched #(.MULT_CYCLES(1), .DIV_CYCLES(15)) dut1 (
        .clk(clk), .reset(reset), .E_start(E_start), .E_is_div(E_is_div),
        .D_md_use(D_md_use), .hz_stall(hz_stall), .busy(busy_w[1]), .md_done(md_done_w[1]),
        .Stall(stall_w[1]), .E_flush(flush_w[1]), .cnt(cnt_w[1]), .stall_cycles(stats_w[1])
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic d, input logic u, input logic h);
        @(posedge clk);
        #1;
        E_start  = s;
        E_is_div = d;
        D_md_use = u;
        hz_stall = h;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    function automatic logic model_stall(int k);
        return hz_stall | (D_md_use & ((m_rem[k] != 0) | E_start));
    endfunction

    // Model: remaining busy cycles per instance; a start only counts when nothing is outstanding.
    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_rem[k]   = 0;
                m_stats[k] = 32'd0;
            end else begin
`ifdef MD_STALL_STATS_EN
                if (model_stall(k)) m_stats[k] = m_stats[k] + 32'd1;
`endif
                if (m_rem[k] > 0) m_rem[k] = m_rem[k] - 1;
                else if (E_start) m_rem[k] = E_is_div ? div_n[k] : mult_n[k];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("cmp%0d_busy", k), busy_w[k], m_rem[k] != 0);
                checkOutput($sformatf("cmp%0d_md_done", k), md_done_w[k], m_rem[k] == 1);
                checkOutput($sformatf("cmp%0d_cnt", k), cnt_w[k], m_rem[k]);
                checkOutput($sformatf("cmp%0d_stall", k), stall_w[k], model_stall(k));
                checkOutput($sformatf("cmp%0d_flush", k), flush_w[k], model_stall(k));
                checkOutput($sformatf("cmp%0d_stats", k), stats_w[k], m_stats[k]);
            end
        end
    end

    initial begin
        int stall_n;
        logic [31:0] exp_stats;

        reset = 1'b1;
        #2;
        checkOutput("reset_busy", busy_w[0], 0);
        checkOutput("reset_cnt", cnt_w[0], 0);
        checkOutput("reset_md_done", md_done_w[0], 0);
        checkOutput("reset_stall", stall_w[0], 0);
        checkOutput("reset_flush", flush_w[0], 0);
        checkOutput("reset_stats", stats_w[0], 0);
        #10 reset = 1'b0;
        cmp_en = 1'b1;

        // mult followed by an md-use instruction held in D
        pulseReset();
        applyStimulus(1, 0, 1, 0);
        #2;
        checkOutput("mult_c0_stall", stall_w[0], 1);
        checkOutput("mult_c0_busy", busy_w[0], 0);
        stall_n = 1;
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(0, 0, 1, 0);
            #2;
            if (stall_w[0]) stall_n++;
            checkOutput($sformatf("mult_c%0d_busy", c), busy_w[0], c <= 5);
            checkOutput($sformatf("mult_c%0d_done", c), md_done_w[0], c == 5);
            checkOutput($sformatf("mult1_c%0d_busy", c), busy_w[1], c == 1);
            checkOutput($sformatf("mult1_c%0d_done", c), md_done_w[1], c == 1);
        end
        checkOutput("mult_c6_stall", stall_w[0], 0);
        checkOutput("mult_stall_count", stall_n, 6);
`ifdef MD_STALL_STATS_EN
        exp_stats = 32'd6;
`else
        exp_stats = 32'd0;
`endif
        checkOutput("mult_stats", stats_w[0], exp_stats);

        // div with independent instructions; D_md_use raised when cnt reaches 4
        pulseReset();
        applyStimulus(1, 1, 0, 0);
        #2;
        checkOutput("div_c0_stall", stall_w[0], 0);
        stall_n = 0;
        for (int c = 1; c <= 11; c++) begin
            applyStimulus(0, 0, c >= 7, 0);
            #2;
            if (stall_w[0]) stall_n++;
            checkOutput($sformatf("div_c%0d_cnt", c), cnt_w[0], 11 - c);
        end
        checkOutput("div_stall_count", stall_n, 4);

        // hazard stall passthrough while idle
        pulseReset();
        applyStimulus(0, 0, 0, 1);
        #2;
        checkOutput("hz_stall", stall_w[0], 1);
        checkOutput("hz_flush", flush_w[0], 1);
        checkOutput("hz_cnt", cnt_w[0], 0);
        applyStimulus(0, 0, 0, 0);

        // asynchronous reset in the middle of a divide, then a clean mult
        pulseReset();
        applyStimulus(1, 1, 0, 0);
        for (int c = 1; c <= 4; c++) applyStimulus(0, 0, 0, 0);
        #1;
        checkOutput("rstdiv_cnt_before", cnt_w[0], 7);
        #1 reset = 1'b1;
        #1;
        checkOutput("rstdiv_busy", busy_w[0], 0);
        checkOutput("rstdiv_cnt", cnt_w[0], 0);
        checkOutput("rstdiv_done", md_done_w[0], 0);
        checkOutput("rstdiv_stats", stats_w[0], 0);
        checkOutput("rstdiv_stall", stall_w[0], 0);
        reset = 1'b0;
        applyStimulus(1, 0, 0, 0);
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(0, 0, 0, 0);
            #2;
            checkOutput($sformatf("rstmult_c%0d_cnt", c), cnt_w[0], 6 - c);
            checkOutput($sformatf("rstmult_c%0d_done", c), md_done_w[0], c == 5);
        end

        // restart attempt while busy must be ignored
        pulseReset();
        applyStimulus(1, 1, 0, 0);
        for (int c = 1; c <= 7; c++) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        #2;
        checkOutput("restart_c8_cnt", cnt_w[0], 3);
        for (int c = 9; c <= 11; c++) begin
            applyStimulus(0, 0, 0, 0);
            #2;
            checkOutput($sformatf("restart_c%0d_cnt", c), cnt_w[0], 11 - c);
        end

        // randomized traffic checked by the compare process
        pulseReset();
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 1),
                          $urandom_range(0, 1), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end

        applyStimulus(0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
